// File: rtl/seq_det_pkg.sv
// Shared types and constants for the RAM bit reader and the 01110 sequence detector.
package seq_det_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   localparam logic [4:0] DET_PATTERN = 5'b01110;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   function automatic logic state_is_busy(input state_t st);
      return (st != ST_IDLE);
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-left register; MSB is the serial output.
module piso_shreg
   import seq_det_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              msb
);

   logic [DATA_W-1:0] shreg_r;

   // Load has priority over shift; zeros fill from the LSB side.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_r <= {DATA_W{1'b0}};
      end else if (load) begin
         shreg_r <= din;
      end else if (shift) begin
         shreg_r <= {shreg_r[DATA_W-2:0], 1'b0};
      end else begin
         shreg_r <= shreg_r;
      end
   end

   assign msb = shreg_r[DATA_W-1];

endmodule

// File: rtl/ram_bit_reader.sv
// Reads a run of RAM words and serialises them MSB-first for the sequence detector.
// Define RAM_BIT_READER_PREFETCH_EN to overlap the next read with the last bits of a word.
module ram_bit_reader
   import seq_det_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_words,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   output logic              a,
   output logic              a_valid,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   words_left_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic              more_s;
   logic              pf_issue_s;
   logic              pf_load_s;
   logic              load_s;
   logic              shift_s;
   logic              msb_s;

   // words_left_r counts words not yet requested from the RAM.
   assign more_s = (words_left_r != {(ADDR_W+1){1'b0}});

`ifdef RAM_BIT_READER_PREFETCH_EN
   localparam logic [CNT_W-1:0] PRE_BIT = CNT_W'(DATA_W - 2);
   logic pf_pending_r;

   assign pf_issue_s = (state_r == ST_SHIFT) && (bit_cnt_r == PRE_BIT) && more_s;
   assign pf_load_s  = (state_r == ST_SHIFT) && (bit_cnt_r == LAST_BIT) && pf_pending_r;
`else
   assign pf_issue_s = 1'b0;
   assign pf_load_s  = 1'b0;
`endif

   assign load_s  = (state_r == ST_LOAD) || pf_load_s;
   assign shift_s = (state_r == ST_SHIFT) && !pf_load_s;

   // Everything below is decoded from registers only, never from inputs.
   assign ram_rd_en = (state_r == ST_FETCH) || pf_issue_s;
   assign ram_addr  = addr_r;
   assign a_valid   = (state_r == ST_SHIFT);
   assign a         = a_valid && msb_s;
   assign busy      = state_is_busy(state_r);
   assign done      = (state_r == ST_FIN);

   // Scan sequencer: addr_r advances and words_left_r drops on every read issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         addr_r       <= {ADDR_W{1'b0}};
         words_left_r <= {(ADDR_W+1){1'b0}};
         bit_cnt_r    <= {CNT_W{1'b0}};
`ifdef RAM_BIT_READER_PREFETCH_EN
         pf_pending_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  if (num_words == {(ADDR_W+1){1'b0}}) begin
                     state_r <= ST_FIN;
                  end else begin
                     addr_r       <= base_addr;
                     words_left_r <= num_words;
                     state_r      <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               addr_r       <= addr_r + ADDR_W'(1);
               words_left_r <= words_left_r - (ADDR_W+1)'(1);
               state_r      <= ST_LOAD;
            end
            ST_LOAD: begin
               bit_cnt_r <= {CNT_W{1'b0}};
               state_r   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (bit_cnt_r == LAST_BIT) begin
                  bit_cnt_r <= {CNT_W{1'b0}};
`ifdef RAM_BIT_READER_PREFETCH_EN
                  if (pf_pending_r) begin
                     pf_pending_r <= 1'b0;
                  end else begin
                     state_r <= ST_FIN;
                  end
`else
                  if (more_s) begin
                     state_r <= ST_FETCH;
                  end else begin
                     state_r <= ST_FIN;
                  end
`endif
               end else begin
                  bit_cnt_r <= bit_cnt_r + CNT_W'(1);
`ifdef RAM_BIT_READER_PREFETCH_EN
                  if (pf_issue_s) begin
                     addr_r       <= addr_r + ADDR_W'(1);
                     words_left_r <= words_left_r - (ADDR_W+1)'(1);
                     pf_pending_r <= 1'b1;
                  end
`endif
               end
            end
            ST_FIN: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   piso_shreg #(
      .DATA_W (DATA_W)
   ) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (load_s),
      .shift (shift_s),
      .din   (ram_data),
      .msb   (msb_s)
   );

endmodule
